prbs_gen: RTL and testbench

Parametrised pseudo-random bit-sequence generator for the Ethernet datapath, used for scrambler seeding, link test patterns and backoff randomisation. Implements a Fibonacci LFSR of configurable width and polynomial, advances a configurable number of steps per clock and emits those bits as a registered parallel word. Adds run-time seed load, enable gating, all-zero lock-up protection and a sequence-wrap indicator.

---
 rtl/prbs_pkg.sv | 30 +++
 rtl/prbs_unroll.sv | 28 ++
 rtl/prbs_gen.sv | 103 ++++++++++
 tb/tb_prbs_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS tap masks, default seeds and single-step LFSR function
package prbs_pkg;

    // Tap masks for a right-shifting Fibonacci LFSR: bit 0 plus the reciprocal tap.
    localparam logic [6:0]  PRBS7_POLY  = 7'h03;
    localparam logic [8:0]  PRBS9_POLY  = 9'h011;
    localparam logic [14:0] PRBS15_POLY = 15'h0003;
    localparam logic [22:0] PRBS23_POLY = 23'h00_0021;
    localparam logic [30:0] PRBS31_POLY = 31'h0000_0009;

    localparam logic [6:0]  PRBS7_SEED  = '1;
    localparam logic [8:0]  PRBS9_SEED  = '1;
    localparam logic [14:0] PRBS15_SEED = '1;
    localparam logic [22:0] PRBS23_SEED = '1;
    localparam logic [30:0] PRBS31_SEED = '1;

    localparam int unsigned PRBS_MAX_W = 64;

    // Operates on a 64-bit container; the caller truncates the result to its width.
    function automatic logic [PRBS_MAX_W-1:0] prbs_step(
        input logic [PRBS_MAX_W-1:0] s,
        input logic [PRBS_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic f;
        f = ^(s & poly);
        return (s >> 1) | ({{(PRBS_MAX_W-1){1'b0}}, f} << (width - 1));
    endfunction

endpackage

// File: rtl/prbs_unroll.sv
// rtl/prbs_unroll.sv - combinational OUT_W-step LFSR unroll with per-step states
module prbs_unroll
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = 5'b00101,
    parameter int unsigned      OUT_W = 1
) (
    input  logic [WIDTH-1:0]       i_state,
    output logic [WIDTH-1:0]       o_state,
    output logic [OUT_W-1:0]       o_bits,
    output logic [OUT_W*WIDTH-1:0] o_mids
);

    logic [WIDTH-1:0] w_chain [0:OUT_W];

    assign w_chain[0] = i_state;

    for (genvar k = 0; k < OUT_W; k++) begin : g_step
        assign w_chain[k+1] = WIDTH'(prbs_step(PRBS_MAX_W'(w_chain[k]),
                                               PRBS_MAX_W'(POLY), WIDTH));
        assign o_bits[k]                = w_chain[k][0];
        assign o_mids[k*WIDTH +: WIDTH] = w_chain[k+1];
    end

    assign o_state = w_chain[OUT_W];

endmodule

// File: rtl/prbs_gen.sv
// rtl/prbs_gen.sv - parametrised Fibonacci PRBS generator, OUT_W bits per enabled cycle
// Optional error injection on dout[0] when PRBS_GEN_ERR_INJ_EN is defined.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = 5'b00101,
    parameter logic [WIDTH-1:0] SEED  = 5'b11110,
    parameter int unsigned      OUT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
`ifdef PRBS_GEN_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup,
    output logic             wrap
);

    logic [WIDTH-1:0]       r_state;
    logic [WIDTH-1:0]       r_start;
    logic [OUT_W-1:0]       r_dout;
    logic                   r_valid;
    logic                   r_lockup;
    logic                   r_wrap;

    logic [WIDTH-1:0]       w_next;
    logic [OUT_W-1:0]       w_bits;
    logic [OUT_W*WIDTH-1:0] w_mids;
    logic                   w_hit;
    logic                   w_seed_zero;
    logic [WIDTH-1:0]       w_load_val;
    logic [OUT_W-1:0]       w_inj;

    prbs_unroll #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .OUT_W (OUT_W)
    ) u_unroll (
        .i_state (r_state),
        .o_state (w_next),
        .o_bits  (w_bits),
        .o_mids  (w_mids)
    );

    // Any post-step state matching the start register means the period closed.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < OUT_W; k++) begin
            if (w_mids[k*WIDTH +: WIDTH] == r_start) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_seed_zero = ~|seed_in;
    assign w_load_val  = w_seed_zero ? SEED : seed_in;

`ifdef PRBS_GEN_ERR_INJ_EN
    assign w_inj = OUT_W'(err_inj);
`else
    assign w_inj = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SEED;
            r_start  <= SEED;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (load) begin
            r_state  <= w_load_val;
            r_start  <= w_load_val;
            r_lockup <= w_seed_zero;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (en) begin
            // Injection touches only the output word; the LFSR keeps the clean sequence.
            r_state  <= w_next;
            r_dout   <= w_bits ^ w_inj;
            r_valid  <= 1'b1;
            r_wrap   <= w_hit;
        end else begin
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign state_o    = r_state;
    assign lockup     = r_lockup;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_prbs_gen.sv
// tb/tb_prbs_gen.sv - directed self-checking bench for prbs_gen (OUT_W=1 and OUT_W=5)
module tb_prbs_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [4:0] seed_in;
`ifdef PRBS_GEN_ERR_INJ_EN
    logic       err_inj;
`endif

    logic       dout1;
    logic       valid1;
    logic [4:0] state1;
    logic       lockup1;
    logic       wrap1;

    logic [4:0] dout5;
    logic       valid5;
    logic [4:0] state5;
    logic       lockup5;
    logic       wrap5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prbs_gen #(.WIDTH(5), .POLY(5'b00101), .SEED(5'b11110), .OUT_W(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
`ifdef PRBS_GEN_ERR_INJ_EN
        .err_inj    (err_inj),
`endif
        .dout       (dout1),
        .dout_valid (valid1),
        .state_o    (state1),
        .lockup     (lockup1),
        .wrap       (wrap1)
    );

    prbs_gen #(.WIDTH(5), .POLY(5'b00101), .SEED(5'b11110), .OUT_W(5)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
`ifdef PRBS_GEN_ERR_INJ_EN
        .err_inj    (err_inj),
`endif
        .dout       (dout5),
        .dout_valid (valid5),
        .state_o    (state5),
        .lockup     (lockup5),
        .wrap       (wrap5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [4:0] exp_state [1:5];
    logic       exp_bit   [1:5];

    initial begin
        exp_state[1] = 5'b11111; exp_bit[1] = 1'b0;
        exp_state[2] = 5'b01111; exp_bit[2] = 1'b1;
        exp_state[3] = 5'b00111; exp_bit[3] = 1'b1;
        exp_state[4] = 5'b00011; exp_bit[4] = 1'b1;
        exp_state[5] = 5'b10001; exp_bit[5] = 1'b1;

        rst_n = 1'b0; en = 1'b0; load = 1'b0; seed_in = 5'b00000;
`ifdef PRBS_GEN_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_state",  64'(state1),  64'h1e);
        chk("rst_dout",   64'(dout1),   64'h0);
        chk("rst_valid",  64'(valid1),  64'h0);
        chk("rst_lockup", 64'(lockup1), 64'h0);
        chk("rst_wrap",   64'(wrap1),   64'h0);
        chk("rst_dout5",  64'(dout5),   64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 31 enabled cycles: first five checked bit by bit, wrap only on the last
        en = 1'b1;
`ifdef PRBS_GEN_ERR_INJ_EN
        err_inj = 1'b1;
`endif
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
`ifdef PRBS_GEN_ERR_INJ_EN
            err_inj = 1'b0;
`endif
            if (i <= 5) begin
`ifdef PRBS_GEN_ERR_INJ_EN
                chk($sformatf("seq_dout%0d", i), 64'(dout1), 64'((i == 1) ? 1'b1 : exp_bit[i]));
`else
                chk($sformatf("seq_dout%0d", i), 64'(dout1), 64'(exp_bit[i]));
`endif
                chk($sformatf("seq_state%0d", i), 64'(state1), 64'(exp_state[i]));
                chk($sformatf("seq_valid%0d", i), 64'(valid1), 64'h1);
            end
            if (i == 1) begin
`ifdef PRBS_GEN_ERR_INJ_EN
                chk("w5_dout", 64'(dout5), 64'h1f);
`else
                chk("w5_dout", 64'(dout5), 64'h1e);
`endif
                chk("w5_state", 64'(state5), 64'h11);
            end
            chk($sformatf("wrap%0d", i), 64'(wrap1), 64'((i == 31) ? 1'b1 : 1'b0));
        end
        chk("wrap_state", 64'(state1), 64'h1e);

        en = 1'b0;
        @(negedge clk);
        chk("idle_valid", 64'(valid1), 64'h0);
        chk("idle_wrap",  64'(wrap1),  64'h0);
        chk("idle_state", 64'(state1), 64'h1e);

        en = 1'b1;
        @(negedge clk);
        chk("pre_load_state", 64'(state1), 64'h1f);

        en = 1'b0; load = 1'b1; seed_in = 5'b00000;
        @(negedge clk);
        chk("zload_state",  64'(state1),  64'h1e);
        chk("zload_lockup", 64'(lockup1), 64'h1);
        chk("zload_valid",  64'(valid1),  64'h0);
        chk("zload_dout",   64'(dout1),   64'h0);

        en = 1'b1; load = 1'b1; seed_in = 5'b00001;
        @(negedge clk);
        chk("ldeen_state",  64'(state1),  64'h01);
        chk("ldeen_valid",  64'(valid1),  64'h0);
        chk("ldeen_lockup", 64'(lockup1), 64'h0);

        load = 1'b0;
        @(negedge clk);
        chk("after_ld_dout",  64'(dout1),  64'h1);
        chk("after_ld_state", 64'(state1), 64'h10);
        chk("after_ld_valid", 64'(valid1), 64'h1);

        // Asynchronous reset mid-stream, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("async_state", 64'(state1), 64'h1e);
        chk("async_valid", 64'(valid1), 64'h0);
        chk("async_dout",  64'(dout1),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_dout",  64'(dout1),  64'h0);
        chk("restart_state", 64'(state1), 64'h1f);
        chk("restart_dout5", 64'(dout5),  64'h1e);

        en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
